// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/stall controller.
// States, the R15 index and the per-source RAW match function live here.
package hazard_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    StInit    = 2'd0,
    StRun     = 2'd1,
    StMemWait = 2'd2
  } state_e;

  // R15 is the PC; reading it never depends on an in-flight writeback.
  localparam logic [3:0] RegPc = 4'hF;

  // One source operand against one producing stage.
  function automatic logic src_hit(input logic [3:0] src,
                                   input logic       src_v,
                                   input logic [3:0] dest,
                                   input logic       wb_en);
    return src_v && (src != RegPc) && (src == dest) && wb_en;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
// Combinational RAW hazard detector for the ID-stage instruction.
// Build option FWD_UNIT_EN: when defined, only EXE load-use hazards stall
// (a forwarding unit covers everything else); otherwise any EXE/MEM match stalls.
module hazard_stall_ctrl_hazard_detect
  import hazard_stall_ctrl_pkg::*;
(
  input  logic [3:0] id_src1_i,
  input  logic       id_src1_v_i,
  input  logic [3:0] id_src2_i,
  input  logic       id_two_src_i,
  input  logic [3:0] exe_dest_i,
  input  logic       exe_wb_en_i,
  input  logic       exe_mem_r_en_i,
  input  logic [3:0] mem_dest_i,
  input  logic       mem_wb_en_i,
  output logic       hazard_o
);

  logic exe_hit;
  logic mem_hit;
  logic unused_fwd;

  // Match both sources against each producing stage.
  always_comb begin
    exe_hit = src_hit(id_src1_i, id_src1_v_i, exe_dest_i, exe_wb_en_i) ||
              src_hit(id_src2_i, id_two_src_i, exe_dest_i, exe_wb_en_i);
    mem_hit = src_hit(id_src1_i, id_src1_v_i, mem_dest_i, mem_wb_en_i) ||
              src_hit(id_src2_i, id_two_src_i, mem_dest_i, mem_wb_en_i);
  end

`ifdef FWD_UNIT_EN
  // Only a load in EXE cannot be forwarded in time.
  assign hazard_o   = exe_mem_r_en_i && exe_hit;
  assign unused_fwd = mem_hit;
`else
  assign hazard_o   = exe_hit || mem_hit;
  assign unused_fwd = exe_mem_r_en_i;
`endif

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Enable/clear control for the 5-stage pipeline registers.
// Handles RAW stalls, taken-branch flushes, data-memory freezes, a one-cycle
// post-reset flush, a saturating stall counter and a sticky memory timeout flag.
// Build option FWD_UNIT_EN selects load-use-only hazard detection.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_src1,
  input  logic             id_src1_v,
  input  logic [3:0]       id_src2,
  input  logic             id_two_src,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_clr,
  output logic             back_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_err
);

  localparam int unsigned      WaitW   = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic hazard;
  logic freeze_req;
  logic run_pc_en, run_ifid_en, run_ifid_flush, run_idex_en, run_idex_clr, run_back_en;

  hazard_stall_ctrl_hazard_detect u_hazard_detect (
    .id_src1_i      (id_src1),
    .id_src1_v_i    (id_src1_v),
    .id_src2_i      (id_src2),
    .id_two_src_i   (id_two_src),
    .exe_dest_i     (exe_dest),
    .exe_wb_en_i    (exe_wb_en),
    .exe_mem_r_en_i (exe_mem_r_en),
    .mem_dest_i     (mem_dest),
    .mem_wb_en_i    (mem_wb_en),
    .hazard_o       (hazard)
  );

  assign freeze_req = mem_req && !mem_ready;

  // Normal-flow decode: branch squashes ID (overriding a hazard), hazard inserts a bubble.
  always_comb begin
    run_pc_en      = 1'b1;
    run_ifid_en    = 1'b1;
    run_ifid_flush = 1'b0;
    run_idex_en    = 1'b1;
    run_idex_clr   = 1'b0;
    run_back_en    = 1'b1;
    if (branch_taken) begin
      run_ifid_flush = 1'b1;
      run_idex_clr   = 1'b1;
    end else if (hazard) begin
      run_pc_en    = 1'b0;
      run_ifid_en  = 1'b0;
      run_idex_clr = 1'b1;
    end
  end

  // Output decode from state and inputs; freeze holds every register with no clears.
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_en    = 1'b0;
    idex_clr   = 1'b0;
    back_en    = 1'b0;
    unique case (state_q)
      StRun, StMemWait: begin
        // In wait, the mem_ready cycle already lets the pipeline advance.
        if ((state_q == StRun && !freeze_req) || (state_q == StMemWait && mem_ready)) begin
          pc_en      = run_pc_en;
          ifid_en    = run_ifid_en;
          ifid_flush = run_ifid_flush;
          idex_en    = run_idex_en;
          idex_clr   = run_idex_clr;
          back_en    = run_back_en;
        end
      end
      default: begin
        ifid_flush = 1'b1;
        idex_clr   = 1'b1;
      end
    endcase
  end

  // Next state, wait counter, timeout flag and stall counter.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        state_d = StRun;
        wait_d  = '0;
      end
      StRun: begin
        if (freeze_req) begin
          state_d = StMemWait;
          wait_d  = WaitW'(1);
        end
      end
      StMemWait: begin
        if (mem_ready) begin
          state_d = StRun;
          wait_d  = '0;
        end else if (wait_q < WaitMax) begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      default: begin
        state_d = StInit;
        wait_d  = '0;
      end
    endcase
    if ((MEM_TIMEOUT != 0) && (state_d == StMemWait) && (wait_d == WaitMax)) begin
      err_d = 1'b1;
    end
    if ((state_q != StInit) && !pc_en && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StInit;
      wait_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign stall_cnt = cnt_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (small counter and timeout
// so saturation and mem_err are reachable quickly).
module tb_hazard_stall_ctrl;

  localparam int unsigned CntW    = 4;
  localparam int unsigned Timeout = 3;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_clr, back_en}
  localparam logic [5:0] CtlInit   = 6'b001010;
  localparam logic [5:0] CtlRun    = 6'b110101;
  localparam logic [5:0] CtlBubble = 6'b000111;
  localparam logic [5:0] CtlFlush  = 6'b111111;
  localparam logic [5:0] CtlFreeze = 6'b000000;

`ifdef FWD_UNIT_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      id_src1, id_src2, exe_dest, mem_dest;
  logic            id_src1_v, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic            branch_taken, mem_req, mem_ready;
  logic            pc_en, ifid_en, ifid_flush, idex_en, idex_clr, back_en;
  logic [CntW-1:0] stall_cnt;
  logic            mem_err;
  logic [5:0]      ctl;

  int vectors     = 0;
  int miscompares = 0;
  int exp_cnt     = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_clr, back_en};

  hazard_stall_ctrl #(
    .CNT_W       (CntW),
    .MEM_TIMEOUT (Timeout)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_src1      (id_src1),
    .id_src1_v    (id_src1_v),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_en      (idex_en),
    .idex_clr     (idex_clr),
    .back_en      (back_en),
    .stall_cnt    (stall_cnt),
    .mem_err      (mem_err)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_src1 = 4'd0; id_src1_v = 1'b0; id_src2 = 4'd0; id_two_src = 1'b0;
    exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    mem_dest = 4'd0; mem_wb_en = 1'b0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic load_use();
    exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd3;
    id_src1 = 4'd3; id_src1_v = 1'b1;
  endtask

  task automatic bump();
    if (exp_cnt < (1 << CntW) - 1) exp_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    #3;
    check("rst_ctl", 16'(ctl), 16'(CtlInit));
    check("rst_cnt", 16'(stall_cnt), 16'd0);
    check("rst_err", 16'(mem_err), 16'd0);

    // Release reset away from the clock edge: one S_INIT cycle follows.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("init_ctl", 16'(ctl), 16'(CtlInit));
    next_cyc();
    #2;
    check("run_ctl", 16'(ctl), 16'(CtlRun));
    check("run_cnt", 16'(stall_cnt), 16'd0);

    // Load-use on Rn: one bubble.
    next_cyc();
    load_use();
    #2;
    check("lu_ctl", 16'(ctl), 16'(CtlBubble));
    next_cyc();
    clear_in();
    bump();
    #2;
    check("lu_cnt", 16'(stall_cnt), 16'(exp_cnt));
    check("lu_after", 16'(ctl), 16'(CtlRun));

    // MEM-stage RAW on second source.
    next_cyc();
    mem_dest = 4'd5; mem_wb_en = 1'b1; id_src2 = 4'd5; id_two_src = 1'b1;
    #2;
    check("memraw_ctl", 16'(ctl), 16'(Fwd ? CtlRun : CtlBubble));
    next_cyc();
    if (!Fwd) bump();
    id_two_src = 1'b0;  // same match but second source unused
    #2;
    check("memraw_cnt", 16'(stall_cnt), 16'(exp_cnt));
    check("memraw_nosrc", 16'(ctl), 16'(CtlRun));

    // EXE match on a non-load.
    next_cyc();
    clear_in();
    exe_wb_en = 1'b1; exe_dest = 4'd7; id_src1 = 4'd7; id_src1_v = 1'b1;
    #2;
    check("exe_alu_ctl", 16'(ctl), 16'(Fwd ? CtlRun : CtlBubble));
    next_cyc();
    clear_in();
    if (!Fwd) bump();

    // Load in EXE but Rn not read.
    load_use();
    id_src1_v = 1'b0;
    #2;
    check("nosrc_ctl", 16'(ctl), 16'(CtlRun));

    // R15 never hazards.
    next_cyc();
    clear_in();
    exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'hF;
    id_src1 = 4'hF; id_src1_v = 1'b1;
    #2;
    check("r15_ctl", 16'(ctl), 16'(CtlRun));

    // Branch with a load-use: branch wins, ID squashed, PC advances.
    next_cyc();
    clear_in();
    load_use();
    branch_taken = 1'b1;
    #2;
    check("br_lu_ctl", 16'(ctl), 16'(CtlFlush));
    check("br_lu_cnt", 16'(stall_cnt), 16'(exp_cnt));

    // Memory freeze for 4 cycles; timeout 3 sets mem_err in the 4th.
    for (int i = 1; i <= 4; i++) begin
      next_cyc();
      clear_in();
      mem_req = 1'b1;
      branch_taken = (i == 4);
      #2;
      check($sformatf("frz_ctl_%0d", i), 16'(ctl), 16'(CtlFreeze));
      check($sformatf("frz_err_%0d", i), 16'(mem_err), 16'(i == 4));
      if (i > 1) bump();
    end
    next_cyc();
    bump();
    mem_req = 1'b1; mem_ready = 1'b1; branch_taken = 1'b1;
    #2;
    check("frz_rdy_ctl", 16'(ctl), 16'(CtlFlush));
    check("frz_cnt", 16'(stall_cnt), 16'(exp_cnt));
    next_cyc();
    clear_in();
    #2;
    check("frz_exit_ctl", 16'(ctl), 16'(CtlRun));
    check("frz_err_sticky", 16'(mem_err), 16'd1);

    // Held hazard: one bubble per cycle, counter saturates without wrapping.
    load_use();
    for (int i = 0; i < 20; i++) begin
      #2;
      check("hold_ctl", 16'(ctl), 16'(CtlBubble));
      next_cyc();
      bump();
    end
    #1;
    check("sat_cnt", 16'(stall_cnt), 16'(exp_cnt));
    check("sat_max", 16'(stall_cnt), 16'hF);
    check("err_still", 16'(mem_err), 16'd1);

    // Asynchronous reset mid-stall.
    #1;
    rst = 1'b1;
    #1;
    exp_cnt = 0;
    check("midrst_ctl", 16'(ctl), 16'(CtlInit));
    check("midrst_cnt", 16'(stall_cnt), 16'(exp_cnt));
    check("midrst_err", 16'(mem_err), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_in();
    #1;
    check("reinit_ctl", 16'(ctl), 16'(CtlInit));
    next_cyc();
    #2;
    check("rerun_ctl", 16'(ctl), 16'(CtlRun));
    check("rerun_cnt", 16'(stall_cnt), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
